// File: rtl/decode_pkg.sv
// Shared decode helpers: the one-hot decode function and the width limit
// used by every decoder instance.
package decode_pkg;

    // Widest select code any decoder instance may be built with.
    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    // Binary code to one-hot. A code containing X or Z bits makes every
    // equality compare unknown, so no bit is set and the result is all zeros;
    // an unknown select therefore never produces a plausible one-hot value.
    function automatic logic [MAX_OUT_W-1:0] onehot_decode(
        input logic [MAX_IN_W-1:0] code
    );
        logic [MAX_OUT_W-1:0] res;
        res = '0;
        for (int k = 0; k < MAX_OUT_W; k++) begin
            if (code == MAX_IN_W'(k)) begin
                res[k] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage : decode_pkg

// File: rtl/decoder_2to4.sv
// Binary-to-one-hot decoder. Combinational by default; REGISTERED=1 adds a
// single output register (1-cycle latency) for timing closure. valid is always
// registered and marks the first clock edge after reset is released.
module decoder_2to4
    import decode_pkg::*;
#(
    parameter int IN_W       = 2,
    parameter bit REGISTERED = 1'b0,
    localparam int OUT_W     = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    // Reject select widths the shared decode function cannot cover.
    if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_width
        $fatal(1, "decoder_2to4: IN_W=%0d is outside 1..%0d", IN_W, MAX_IN_W);
    end

    logic [MAX_IN_W-1:0] code_ext;
    logic [OUT_W-1:0]    decoded;

    // Widen the select code to the function's argument width, then keep only
    // the output bits this instance owns.
    always_comb begin
        // NOTE: every combinational output gets a default before any partial
        // assignment, so no path leaves it holding its old value (no latch).
        code_ext            = '0;
        code_ext[IN_W-1:0]  = in;
        decoded             = OUT_W'(onehot_decode(code_ext));
    end

    // valid: low while rst is sampled high, high from the first edge after.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples its inputs from before the edge, independent of block order.
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= 1'b1;
        end
    end

    if (REGISTERED) begin : g_registered
        // Registered decode: cleared on the edge rst is seen, otherwise it
        // captures this cycle's code for presentation one cycle later.
        always_ff @(posedge clk) begin
            if (rst) begin
                out <= '0;
            end else begin
                out <= decoded;
            end
        end
    end else begin : g_combinational
        // Zero-latency decode; independent of clk and rst by design.
        assign out = decoded;
    end

endmodule : decoder_2to4

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: combinational and registered modes at
// IN_W=2 and IN_W=3, compared against a shift-based one-hot reference model.
module tb_decoder_2to4;

    logic       clk;
    logic       rst;
    logic [1:0] in2;
    logic [2:0] in3;

    logic [3:0] c2_out, r2_out;
    logic [7:0] c3_out, r3_out;
    logic       c2_valid, r2_valid, c3_valid, r3_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Inputs applied at the previous negedge, i.e. what the last posedge saw.
    logic       prev_rst = 1'b1;
    logic [1:0] prev2    = '0;
    logic [2:0] prev3    = '0;

    decoder_2to4 #(.IN_W(2), .REGISTERED(1'b0)) u_c2 (
        .clk(clk), .rst(rst), .in(in2), .out(c2_out), .valid(c2_valid));
    decoder_2to4 #(.IN_W(2), .REGISTERED(1'b1)) u_r2 (
        .clk(clk), .rst(rst), .in(in2), .out(r2_out), .valid(r2_valid));
    decoder_2to4 #(.IN_W(3), .REGISTERED(1'b0)) u_c3 (
        .clk(clk), .rst(rst), .in(in3), .out(c3_out), .valid(c3_valid));
    decoder_2to4 #(.IN_W(3), .REGISTERED(1'b1)) u_r3 (
        .clk(clk), .rst(rst), .in(in3), .out(r3_out), .valid(r3_valid));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: out = 1 << code for a known code, all zeros otherwise.
    function automatic logic [7:0] ref_onehot(input logic [2:0] code);
        if ($isunknown(code)) return 8'd0;
        return 8'd1 << code;
    endfunction

    // Expected popcount: one for a known, decoded code; zero otherwise.
    function automatic logic [7:0] ref_pop(input logic [2:0] code, input logic in_reset);
        if (in_reset || $isunknown(code)) return 8'd0;
        return 8'd1;
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One cycle: at the negedge, check what the previous posedge registered,
    // then apply new inputs and check the combinational outputs.
    task automatic drive(input logic rst_v, input logic [1:0] code2, input logic [2:0] code3);
        logic [7:0] e2, e3, vexp;
        @(negedge clk);
        e2   = prev_rst ? 8'd0 : ref_onehot({1'b0, prev2});
        e3   = prev_rst ? 8'd0 : ref_onehot(prev3);
        vexp = {7'd0, ~prev_rst};
        check("r2_out",   {4'd0, r2_out}, e2);
        check("r3_out",   r3_out, e3);
        check("r2_pop",   8'($countones(r2_out)), ref_pop({1'b0, prev2}, prev_rst));
        check("r3_pop",   8'($countones(r3_out)), ref_pop(prev3, prev_rst));
        check("r2_valid", {7'd0, r2_valid}, vexp);
        check("c2_valid", {7'd0, c2_valid}, vexp);
        check("r3_valid", {7'd0, r3_valid}, vexp);
        check("c3_valid", {7'd0, c3_valid}, vexp);

        rst = rst_v;
        in2 = code2;
        in3 = code3;
        prev_rst = rst_v;
        prev2    = code2;
        prev3    = code3;

        #1;
        check("c2_out", {4'd0, c2_out}, ref_onehot({1'b0, code2}));
        check("c3_out", c3_out, ref_onehot(code3));
        check("c2_pop", 8'($countones(c2_out)), ref_pop({1'b0, code2}, 1'b0));
        check("c3_pop", 8'($countones(c3_out)), ref_pop(code3, 1'b0));
    endtask

    initial begin
        rst = 1'b1;
        in2 = '0;
        in3 = '0;

        // Hold reset: registered outputs and valid stay cleared.
        drive(1'b1, 2'd0, 3'd0);
        drive(1'b1, 2'd0, 3'd0);

        // Combinational sweep during reset: decode does not gate on valid.
        drive(1'b1, 2'd0, 3'd0);
        drive(1'b1, 2'd1, 3'd1);
        drive(1'b1, 2'd2, 3'd2);
        drive(1'b1, 2'd3, 3'd3);

        // Unknown select decodes to zeros, then a known code recovers.
        drive(1'b1, 2'bx1, 3'd0);
        drive(1'b1, 2'd1, 3'd0);

        // Release reset and step codes on consecutive edges.
        drive(1'b0, 2'd0, 3'd0);
        drive(1'b0, 2'd1, 3'd1);
        drive(1'b0, 2'd2, 3'd2);
        drive(1'b0, 2'd3, 3'd3);

        // Reset mid-stream with 0100 on the registered output.
        drive(1'b0, 2'd2, 3'd4);
        drive(1'b1, 2'd3, 3'd5);
        drive(1'b0, 2'd3, 3'd6);
        drive(1'b0, 2'd3, 3'd7);
        drive(1'b0, 2'd3, 3'd7);

        // Unknown select in registered mode, outside reset.
        drive(1'b0, 2'b1x, 3'b0x1);
        drive(1'b0, 2'd2, 3'd2);

        // Full IN_W=3 sweep.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'(i), 3'(i));
        end

        // Random soak with occasional reset pulses.
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 49) == 0), 2'($urandom), 3'($urandom));
        end

        // Flush the last registered value.
        drive(1'b0, 2'd0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decoder_2to4
